// File: rtl/sbox_fill_ctrl.sv
// S-box fill sequencer (duplicate-rejecting permutation builder) and round-robin
// lookup arbiter. Optional inverse-table write port: define SBOX_FILL_INV_EN.
module sbox_fill_ctrl #(
  parameter int MAX_TRIES = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cand_valid,
  input  logic [7:0] cand_data,
  output logic       cand_ready,
  output logic       sbox_we,
  output logic [7:0] sbox_waddr,
  output logic [7:0] sbox_wdata,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] addr0,
  input  logic [7:0] addr1,
  output logic       gnt0,
  output logic       gnt1,
  output logic [7:0] sbox_raddr,
  input  logic [7:0] sbox_rdata,
  output logic       rvalid0,
  output logic       rvalid1,
  output logic [7:0] rdata
`ifdef SBOX_FILL_INV_EN
  ,
  output logic       inv_we,
  output logic [7:0] inv_waddr,
  output logic [7:0] inv_wdata
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_SERVE = 2'd2;
  localparam logic [1:0] S_ERR   = 2'd3;

  logic [1:0]   state;
  logic [255:0] used;
  logic [8:0]   idx;
  logic [15:0]  tries;
  logic         ptr;
  logic         hs, uniq;
  logic [8:0]   idx_nx;
  logic [15:0]  tries_nx;

  assign cand_ready = (state == S_FILL);
  assign busy       = (state == S_FILL);
  assign done       = (state == S_SERVE);
  assign err        = (state == S_ERR);
  assign hs         = cand_valid & cand_ready;
  assign uniq       = hs & ~used[cand_data];
  assign idx_nx     = idx + 9'(uniq);
  assign tries_nx   = tries + 16'd1;
  assign rdata      = sbox_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      used  <= '0;
      idx   <= '0;
      tries <= '0;
    end else if (start && state != S_FILL) begin
      state <= S_FILL;
      used  <= '0;
      idx   <= '0;
      tries <= '0;
    end else if (hs) begin
      tries <= tries_nx;
      idx   <= idx_nx;
      if (uniq) used[cand_data] <= 1'b1;
      // Completing the table wins over a simultaneous try-limit hit.
      if (idx_nx == 9'd256)
        state <= S_SERVE;
      else if (tries_nx == 16'(MAX_TRIES))
        state <= S_ERR;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sbox_we    <= 1'b0;
      sbox_waddr <= '0;
      sbox_wdata <= '0;
    end else begin
      sbox_we <= uniq;
      if (uniq) begin
        sbox_waddr <= idx[7:0];
        sbox_wdata <= cand_data;
      end
    end
  end

`ifdef SBOX_FILL_INV_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inv_we    <= 1'b0;
      inv_waddr <= '0;
      inv_wdata <= '0;
    end else begin
      inv_we <= uniq;
      if (uniq) begin
        inv_waddr <= cand_data;
        inv_wdata <= idx[7:0];
      end
    end
  end
`endif

  // ptr names the requester that wins a tie.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == S_SERVE) begin
      if (req0 && (!req1 || !ptr)) gnt0 = 1'b1;
      else if (req1)               gnt1 = 1'b1;
    end
  end

  assign sbox_raddr = gnt0 ? addr0 : (gnt1 ? addr1 : 8'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr     <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      rvalid0 <= gnt0;
      rvalid1 <= gnt1;
      if (gnt0)      ptr <= 1'b1;
      else if (gnt1) ptr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sbox_fill_ctrl.sv
// Self-checking bench for sbox_fill_ctrl: randomized fills and lookups checked
// against a first-occurrence permutation model and a simple fairness model.
module tb_sbox_fill_ctrl;
  localparam int MT = 300;

  logic       clk = 1'b0;
  logic       rst, start, cand_valid, cand_ready;
  logic [7:0] cand_data;
  logic       sbox_we, busy, done, err;
  logic [7:0] sbox_waddr, sbox_wdata;
  logic       req0, req1, gnt0, gnt1, rvalid0, rvalid1;
  logic [7:0] addr0, addr1, sbox_raddr, sbox_rdata, rdata;
`ifdef SBOX_FILL_INV_EN
  logic       inv_we;
  logic [7:0] inv_waddr, inv_wdata;
  logic [7:0] inv_mem [256];
`endif

  sbox_fill_ctrl #(.MAX_TRIES(MT)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cand_valid(cand_valid), .cand_data(cand_data), .cand_ready(cand_ready),
    .sbox_we(sbox_we), .sbox_waddr(sbox_waddr), .sbox_wdata(sbox_wdata),
    .busy(busy), .done(done), .err(err),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .gnt0(gnt0), .gnt1(gnt1), .sbox_raddr(sbox_raddr), .sbox_rdata(sbox_rdata),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata)
`ifdef SBOX_FILL_INV_EN
    , .inv_we(inv_we), .inv_waddr(inv_waddr), .inv_wdata(inv_wdata)
`endif
  );

  always #5 clk = ~clk;

  // S-box memory with one-cycle read latency.
  logic [7:0] mem [256];
  logic [7:0] mem_rd = 8'd0;
  always @(posedge clk) begin
    if (sbox_we) mem[sbox_waddr] <= sbox_wdata;
    mem_rd <= mem[sbox_raddr];
  end
  assign sbox_rdata = mem_rd;
`ifdef SBOX_FILL_INV_EN
  always @(posedge clk) if (inv_we) inv_mem[inv_waddr] <= inv_wdata;
`endif

  int tests = 0, fails = 0;
  bit         seen [256];
  logic [7:0] tab  [256];
  int         m_idx, m_tries;
  bit         m_ptr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_start();
    foreach (seen[i]) seen[i] = 1'b0;
    m_idx = 0;
    m_tries = 0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    model_start();
    chk("start_busy", busy, 1);
    chk("start_ready", cand_ready, 1);
    chk("start_done", done, 0);
  endtask

  task automatic feed(input logic [7:0] b);
    bit u;
    cand_valid = 1'b1;
    cand_data  = b;
    @(posedge clk); #1;
    cand_valid = 1'b0;
    u = !seen[b];
    chk("we", sbox_we, u);
    if (u) begin
      chk("waddr", sbox_waddr, m_idx[7:0]);
      chk("wdata", sbox_wdata, b);
      seen[b] = 1'b1;
      tab[m_idx] = b;
      m_idx++;
    end
    m_tries++;
    chk("done", done, m_idx == 256);
    chk("err", err, (m_idx < 256) && (m_tries == MT));
    chk("busy", busy, !((m_idx == 256) || (m_tries == MT)));
  endtask

  task automatic gap();
    @(posedge clk); #1;
    chk("gap_we", sbox_we, 0);
  endtask

  task automatic rand_fill(input int max_dup);
    logic [7:0] perm [256];
    logic [7:0] t;
    int j, dups;
    dups = 0;
    for (int i = 0; i < 256; i++) perm[i] = 8'(i);
    for (int i = 255; i > 0; i--) begin
      j = $urandom_range(i, 0);
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int i = 0; i < 256; i++) begin
      if ($urandom_range(7, 0) == 0) gap();
      if (i > 0 && dups < max_dup && $urandom_range(5, 0) == 0) begin
        feed(perm[$urandom_range(i - 1, 0)]);
        dups++;
      end
      feed(perm[i]);
    end
  endtask

  // Requests held until granted; results must come back one cycle after grant.
  task automatic lookups(input int n, input bit serve, input bit directed);
    bit p0, p1, pg0, pg1, eg0, eg1;
    logic [7:0] a0, a1, pa;
    p0 = 0; p1 = 0; pg0 = 0; pg1 = 0; a0 = 0; a1 = 0; pa = 0;
    for (int k = 0; k < n; k++) begin
      if (!p0 && (directed || $urandom_range(1, 0) == 1)) begin
        p0 = 1; a0 = directed ? 8'h10 : 8'($urandom);
      end
      if (!p1 && (directed || $urandom_range(1, 0) == 1)) begin
        p1 = 1; a1 = directed ? 8'h20 : 8'($urandom);
      end
      req0 = p0; addr0 = a0; req1 = p1; addr1 = a1;
      #1;
      eg0 = serve && p0 && (!p1 || !m_ptr);
      eg1 = serve && p1 && !eg0;
      chk("gnt0", gnt0, eg0);
      chk("gnt1", gnt1, eg1);
      chk("raddr", sbox_raddr, eg0 ? a0 : (eg1 ? a1 : 8'd0));
      if (directed) chk("alt", gnt0, (k % 2) == 0);
      if (eg0) begin p0 = 0; m_ptr = 1; pa = a0; end
      if (eg1) begin p1 = 0; m_ptr = 0; pa = a1; end
      pg0 = eg0; pg1 = eg1;
      @(posedge clk); #1;
      chk("rvalid0", rvalid0, pg0);
      chk("rvalid1", rvalid1, pg1);
      if (pg0 || pg1) chk("rdata", rdata, tab[pa]);
    end
    req0 = 0; req1 = 0;
  endtask

  initial begin
    logic [7:0] sv;
    rst = 1'b1; start = 0; cand_valid = 0; cand_data = 0;
    req0 = 0; req1 = 0; addr0 = 0; addr1 = 0;
    m_ptr = 0;
    model_start();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_we", sbox_we, 0);
    chk("rst_ready", cand_ready, 0);
    req0 = 1; req1 = 1; #1;
    chk("rst_gnt", {gnt0, gnt1}, 0);
    req0 = 0; req1 = 0;
    rst = 1'b0;
    gap();

    // Duplicates dropped, then partial fill aborted by reset.
    do_start();
    feed(8'h05); feed(8'h05); feed(8'h07);
    chk("dup_idx", m_idx, 2);
    while (m_idx < 100) feed(8'($urandom));
    rst = 1'b1; #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_we", sbox_we, 0);
    chk("midrst_done", done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_ptr = 0;

    // Refill from a cleared bitmap; start during fill must be ignored.
    do_start();
    feed(8'h03);
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    chk("ign_busy", busy, 1);
    feed(8'h03);
    for (int b = 0; b < 256; b++) feed(8'(b));
    gap();
    lookups(4, 1'b1, 1'b1);
    lookups(60, 1'b1, 1'b0);

    // Restart from SERVE with a lookup granted in the same cycle.
    sv = 8'($urandom);
    req0 = 1; addr0 = sv; start = 1; #1;
    chk("last_gnt0", gnt0, 1);
    m_ptr = 1;
    @(posedge clk); #1;
    start = 0; req0 = 0;
    chk("last_rvalid", rvalid0, 1);
    chk("last_rdata", rdata, tab[sv]);
    chk("restart_done", done, 0);
    chk("restart_busy", busy, 1);
    model_start();
    rand_fill(40);
    gap();
`ifdef SBOX_FILL_INV_EN
    for (int i = 0; i < 256; i++) chk("inverse", inv_mem[tab[i]], i);
`endif
    lookups(60, 1'b1, 1'b0);

    // Timeout: a single repeated byte exhausts the try budget.
    do_start();
    for (int k = 0; k < MT; k++) feed(8'h11);
    chk("to_ready", cand_ready, 0);
    chk("to_idx", m_idx, 1);
    gap();
    lookups(8, 1'b0, 1'b0);
    do_start();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/sbox_fill_ctrl.md
# sbox_fill_ctrl

Sequencer and access arbiter for the 256-entry substitution table in the chaos-based image cipher. During fill, it takes candidate bytes from the chaotic key-stream generator and discards duplicates, so the table becomes a true permutation of 0x00–0xFF. It writes each accepted byte into the S-box memory write port. After the fill, it shares the single S-box read port between the encrypt and decrypt datapaths with round-robin arbitration.

## Interface
- MAX_TRIES, 4096: candidate handshakes allowed per fill before it aborts; range 256..65535.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse; begins or restarts a fill.
- cand_valid  in  1  a candidate byte is present.
- cand_data  in  8  candidate byte from the chaotic generator.
- cand_ready  out  1  controller accepts a candidate this cycle.
- sbox_we  out  1  S-box write strobe.
- sbox_waddr  out  8  S-box write index.
- sbox_wdata  out  8  S-box write data.
- busy  out  1  a fill is in progress.
- done  out  1  table complete; the lookup service is active.
- err  out  1  fill aborted because the MAX_TRIES limit was reached.
- req0/req1  in  1  lookup requests: 0 = encrypt, 1 = decrypt.
- addr0/addr1  in  8  lookup index for each requester.
- gnt0/gnt1  out  1  grant to each requester; combinational.
- sbox_raddr  out  8  S-box read index; the memory returns data one cycle later.
- sbox_rdata  in  8  S-box read data.
- rvalid0/rvalid1  out  1  lookup result valid for each requester.
- rdata  out  8  lookup result; equals sbox_rdata.

## Operation
- States: IDLE, FILL, SERVE, ERR. Reset enters IDLE.
- IDLE to FILL on start. Entering FILL clears the 256-bit used bitmap, idx (9-bit) and tries (16-bit).
- start in SERVE or ERR also re-enters FILL with the same clears. start during FILL is ignored.
- FILL:
  - cand_ready=1.
  - A handshake is cand_valid & cand_ready.
  - Every handshake increments tries.
  - If used[cand_data]=0: set the bit, write entry idx ← cand_data, then increment idx.
  - Duplicates are dropped with no write.
- FILL to SERVE when the 256th unique byte is accepted, i.e. idx reaches 256.
- FILL to ERR when tries reaches MAX_TRIES and idx<256. If both conditions hit on the same handshake, the unique write takes priority and the next state is SERVE.
- SERVE:
  - done=1, cand_ready=0.
  - Requests are arbitrated round-robin; pointer reset value = requester 0.
  - Only one request: it is granted.
  - Both requesting: the pointer's requester is granted.
  - After each grant the pointer moves to the other requester.
  - sbox_raddr = granted address; it holds 0 when nothing is granted.
- Grants occur only in SERVE. gnt0/gnt1 are 0 in all other states.
- busy=1 only in FILL. err=1 only in ERR.

## Timing
- Reset value of every registered output and internal register is 0.
- sbox_we, sbox_waddr and sbox_wdata are registered. The write strobe rises one cycle after the accepting handshake.
- done rises one cycle after the handshake that completes the table. The final write and done are asserted in the same cycle.
- Lookup latency: rvalidN is asserted the cycle after gntN, for exactly one cycle. rdata = sbox_rdata during that cycle.
- Back-to-back requests are granted every cycle. Requesters must hold req and addr until granted.
- rst asserted mid-fill:
  - Returns to IDLE immediately.
  - sbox_we drops asynchronously.
  - A partial table is not marked done.
- A restart from SERVE drops done on the next clock. A lookup granted in the last SERVE cycle still returns its rvalid.

## Configuration
- SBOX_FILL_INV_EN defined:
  - Adds outputs inv_we (1), inv_waddr (8) and inv_wdata (8).
  - On each unique write, inv_waddr=cand_data and inv_wdata=idx[7:0], with the same timing as sbox_we.
  - This fills the inverse table in parallel for decryption.
- SBOX_FILL_INV_EN undefined: the ports and logic are absent. The decrypt path then builds its inverse table externally.

## Test plan
- Ascending feed: start, then feed bytes 0x00..0xFF, one per cycle → 256 writes with waddr=wdata; done rises at cycle 257 after the first handshake; tries=256.
- Duplicates: feed 0x05, 0x05, 0x07 → writes (0,0x05) and (1,0x07) only; idx=2.
- Timeout: MAX_TRIES=300, feed only 0x11 repeatedly → one write, then err=1 after the 300th handshake; cand_ready=0.
- Arbitration in SERVE:
  - req0 and req1 held high with addr0=0x10, addr1=0x20 → grants alternate 0,1,0,1.
  - rvalid follows each grant by one cycle.
  - rdata = table[0x10] and table[0x20] respectively.
- Reset mid-fill after 100 unique bytes → busy=0, sbox_we=0 immediately. A new start refills from idx=0 with a cleared bitmap: 0x03 previously written is accepted again.
- With SBOX_FILL_INV_EN defined, after any full fill → inverse[sbox[i]]=i for all 256 i.
